// File: rtl/cu_pkg.sv
// Shared types and constants for the music calculator control unit.
package cu_pkg;

    // Operator key codes as delivered by the keypad scanner.
    localparam logic [2:0] OP_CLR  = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_SUB  = 3'd2;
    localparam logic [2:0] OP_CMP  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;

    // One BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Four BCD digits; index 3 is thousands and index 0 is units.
    typedef bcd_digit_t [3:0] bcd4_t;

    // Signed-magnitude accumulator value.
    typedef struct packed {
        logic  neg;
        bcd4_t mag;
    } smag_t;

    // Which value the display digits currently reflect.
    typedef enum logic {
        DISP_ENTRY  = 1'b0,
        DISP_RESULT = 1'b1
    } disp_sel_t;

    localparam bcd4_t BCD_ZERO = '0;

    // Shift a 4-digit BCD value left by one digit and insert a new units digit.
    function automatic bcd4_t bcdShiftIn(input bcd4_t value, input bcd_digit_t digit);
        bcd4_t result;
        result[3] = value[2];
        result[2] = value[1];
        result[1] = value[0];
        result[0] = digit;
        return result;
    endfunction

endpackage

// File: rtl/cu_bcd4_addsub.sv
// Four-digit BCD magnitude adder/subtractor.
// Subtraction always returns |X-Y|; the borrow flag tells the caller that X<Y.
module bcd4_addsub
    import cu_pkg::*;
(
    input  bcd4_t i_x,
    input  bcd4_t i_y,
    input  logic  i_mode,
    output bcd4_t o_mag,
    output logic  o_carry,
    output logic  o_borrow
);

    // Ripple BCD add; returns {carry, sum mod 10000}.
    function automatic logic [16:0] addDigits(input bcd4_t a, input bcd4_t b);
        logic       c;
        logic [4:0] s;
        bcd4_t      r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            s = {1'b0, a[i]} + {1'b0, b[i]} + {4'b0000, c};
            if (s > 5'd9) begin
                r[i] = 4'(s - 5'd10);
                c    = 1'b1;
            end else begin
                r[i] = s[3:0];
                c    = 1'b0;
            end
        end
        return {c, r};
    endfunction

    // Ripple BCD subtract a-b; returns {borrow, ten's-complement difference}.
    // Adding ten up front keeps every intermediate non-negative.
    function automatic logic [16:0] subDigits(input bcd4_t a, input bcd4_t b);
        logic       c;
        logic [4:0] t;
        bcd4_t      r;
        c = 1'b0;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            t = {1'b0, a[i]} + 5'd10 - {1'b0, b[i]} - {4'b0000, c};
            if (t >= 5'd10) begin
                r[i] = 4'(t - 5'd10);
                c    = 1'b0;
            end else begin
                r[i] = t[3:0];
                c    = 1'b1;
            end
        end
        return {c, r};
    endfunction

    logic [16:0] w_add;
    logic [16:0] w_subXY;
    logic [16:0] w_subYX;

    assign w_add   = addDigits(i_x, i_y);
    assign w_subXY = subDigits(i_x, i_y);
    assign w_subYX = subDigits(i_y, i_x);

    // Pick the sum or the correctly oriented difference.
    always_comb begin
        o_mag    = w_add[15:0];
        o_carry  = 1'b0;
        o_borrow = 1'b0;
        if (i_mode) begin
            o_borrow = w_subXY[16];
            o_mag    = w_subXY[16] ? w_subYX[15:0] : w_subXY[15:0];
        end else begin
            o_carry  = w_add[16];
        end
    end

endmodule

// File: rtl/cu.sv
// Control unit of the music calculator: key edge detection, entry buffer,
// signed accumulator and registered display/flag outputs.
module cu
    import cu_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] num,
    input  logic       numPressed,
    input  logic [2:0] opt,
    input  logic       optPressed,
    input  logic       submit,
    output logic [3:0] num1,
    output logic [3:0] num2,
    output logic [3:0] num3,
    output logic [3:0] num4,
    output logic       sign,
    output logic       clcCo,
    output logic       clcZero,
    output logic       cmpSign
);

    logic      r_numPrev, r_optPrev, r_subPrev;
    logic      r_numArmed, r_optArmed, r_subArmed;
    bcd4_t     r_entry;
    logic [2:0] r_count;
    smag_t     r_acc;
    logic [2:0] r_pendOp;
    disp_sel_t r_dispSel;
    bcd4_t     r_disp;
    logic      r_sign, r_clcCo, r_clcZero, r_cmpSign;

    logic      w_subEvt, w_optEvt, w_numEvt;
    logic      w_auMode, w_auSwap;
    bcd4_t     w_auX, w_auY, w_auMag;
    logic      w_auCarry, w_auBorrow;
    logic      w_arithNeg, w_arithZero, w_arithCo;
    logic      w_cmpLt, w_cmpEq;
    bcd4_t     w_entryNext;
    logic      w_digitAccept;

    // Sample key levels; a key is armed only once it has been seen low, so a
    // key held through reset must be released before it can fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_numPrev  <= 1'b0;
            r_optPrev  <= 1'b0;
            r_subPrev  <= 1'b0;
            r_numArmed <= 1'b0;
            r_optArmed <= 1'b0;
            r_subArmed <= 1'b0;
        end else begin
            r_numPrev  <= numPressed;
            r_optPrev  <= optPressed;
            r_subPrev  <= submit;
            r_numArmed <= r_numArmed | ~numPressed;
            r_optArmed <= r_optArmed | ~optPressed;
            r_subArmed <= r_subArmed | ~submit;
        end
    end

    assign w_subEvt = submit     & ~r_subPrev & r_subArmed;
    assign w_optEvt = optPressed & ~r_optPrev & r_optArmed & ~w_subEvt;
    assign w_numEvt = numPressed & ~r_numPrev & r_numArmed & ~w_subEvt & ~w_optEvt;

    // Map the pending operator and accumulator sign onto one magnitude add or
    // subtract; E-A needs the operands swapped.
    always_comb begin
        w_auMode = ((r_pendOp == OP_ADD) &&  r_acc.neg) ||
                   ((r_pendOp == OP_SUB) && !r_acc.neg);
        w_auSwap = (r_pendOp == OP_ADD) && r_acc.neg;
        w_auX    = w_auSwap ? r_entry   : r_acc.mag;
        w_auY    = w_auSwap ? r_acc.mag : r_entry;
    end

    bcd4_addsub u_addsub (
        .i_x      (w_auX),
        .i_y      (w_auY),
        .i_mode   (w_auMode),
        .o_mag    (w_auMag),
        .o_carry  (w_auCarry),
        .o_borrow (w_auBorrow)
    );

    // Result sign: a subtract is negative on borrow, an add is negative only
    // for -(A+E), which arises from SUB with a negative accumulator.
    always_comb begin
        w_arithNeg  = w_auMode ? w_auBorrow : (r_pendOp == OP_SUB);
        w_arithZero = (w_auMag == BCD_ZERO);
        w_arithCo   = w_auMode ? 1'b0 : w_auCarry;
    end

    // Signed compare of the accumulator against the non-negative entry.
    // BCD digits order the same as binary, so plain unsigned compares work.
    always_comb begin
        if (r_acc.neg) begin
            w_cmpLt = (r_acc.mag != BCD_ZERO) || (r_entry != BCD_ZERO);
            w_cmpEq = (r_acc.mag == BCD_ZERO) && (r_entry == BCD_ZERO);
        end else begin
            w_cmpLt = (r_acc.mag <  r_entry);
            w_cmpEq = (r_acc.mag == r_entry);
        end
    end

    // Entry after a digit key: restart when a result is on display, otherwise
    // shift in while there is room.
    always_comb begin
        w_digitAccept = 1'b0;
        w_entryNext   = r_entry;
        if (r_dispSel == DISP_RESULT) begin
            w_digitAccept = 1'b1;
            w_entryNext   = bcdShiftIn(BCD_ZERO, num);
        end else if (r_count < 3'd4) begin
            w_digitAccept = 1'b1;
            w_entryNext   = bcdShiftIn(r_entry, num);
        end
    end

    // Key handling: submit beats opt beats digit; only the winner updates state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_entry   <= BCD_ZERO;
            r_count   <= 3'd0;
            r_acc     <= '0;
            r_pendOp  <= OP_ADD;
            r_dispSel <= DISP_ENTRY;
            r_disp    <= BCD_ZERO;
            r_sign    <= 1'b0;
            r_clcCo   <= 1'b0;
            r_clcZero <= 1'b0;
            r_cmpSign <= 1'b0;
        end else if (w_subEvt) begin
            r_count   <= 3'd0;
            r_dispSel <= DISP_RESULT;
            case (r_pendOp)
                OP_ADD, OP_SUB: begin
                    r_acc.neg <= w_arithNeg & ~w_arithZero;
                    r_acc.mag <= w_auMag;
                    r_disp    <= w_auMag;
                    r_sign    <= w_arithNeg & ~w_arithZero;
                    r_clcCo   <= w_arithCo;
                    r_clcZero <= w_arithZero;
                end
                OP_LOAD: begin
                    r_acc.neg <= 1'b0;
                    r_acc.mag <= r_entry;
                    r_disp    <= r_entry;
                    r_sign    <= 1'b0;
                    r_clcCo   <= 1'b0;
                    r_clcZero <= (r_entry == BCD_ZERO);
                end
                OP_CMP: begin
                    r_disp    <= r_acc.mag;
                    r_sign    <= r_acc.neg;
                    r_cmpSign <= w_cmpLt;
                    r_clcZero <= w_cmpEq;
                end
                default: begin
                end
            endcase
        end else if (w_optEvt) begin
            if (opt == OP_CLR) begin
                r_entry   <= BCD_ZERO;
                r_count   <= 3'd0;
                r_acc     <= '0;
                r_pendOp  <= OP_ADD;
                r_dispSel <= DISP_ENTRY;
                r_disp    <= BCD_ZERO;
                r_sign    <= 1'b0;
                r_clcCo   <= 1'b0;
                r_clcZero <= 1'b0;
                r_cmpSign <= 1'b0;
            end else if (opt <= OP_LOAD) begin
                r_pendOp  <= opt;
                r_entry   <= BCD_ZERO;
                r_count   <= 3'd0;
                r_dispSel <= DISP_ENTRY;
                r_disp    <= BCD_ZERO;
                r_sign    <= 1'b0;
            end
        end else if (w_numEvt && (num <= 4'd9) && w_digitAccept) begin
            r_entry   <= w_entryNext;
            r_count   <= (r_dispSel == DISP_RESULT) ? 3'd1 : 3'(r_count + 3'd1);
            r_dispSel <= DISP_ENTRY;
            r_disp    <= w_entryNext;
            r_sign    <= 1'b0;
        end
    end

    assign num1    = r_disp[3];
    assign num2    = r_disp[2];
    assign num3    = r_disp[1];
    assign num4    = r_disp[0];
    assign sign    = r_sign;
    assign clcCo   = r_clcCo;
    assign clcZero = r_clcZero;
    assign cmpSign = r_cmpSign;

endmodule

// File: tb/tb_cu.sv
// Directed bench for the calculator control unit. Expected outputs are packed
// as 20'hDDDDF: four display digits then {sign, clcCo, clcZero, cmpSign}.
module tb_cu;

    logic       clk;
    logic       reset;
    logic [3:0] num;
    logic       numPressed;
    logic [2:0] opt;
    logic       optPressed;
    logic       submit;
    logic [3:0] num1, num2, num3, num4;
    logic       sign, clcCo, clcZero, cmpSign;

    int checks   = 0;
    int failures = 0;

    cu dut (
        .clk        (clk),
        .reset      (reset),
        .num        (num),
        .numPressed (numPressed),
        .opt        (opt),
        .optPressed (optPressed),
        .submit     (submit),
        .num1       (num1),
        .num2       (num2),
        .num3       (num3),
        .num4       (num4),
        .sign       (sign),
        .clcCo      (clcCo),
        .clcZero    (clcZero),
        .cmpSign    (cmpSign)
    );

    // Free-running 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare every output against a hand-computed packed value.
    task automatic checkOutput(input string tag, input logic [19:0] expected);
        logic [19:0] observed;
        observed = {num1, num2, num3, num4, sign, clcCo, clcZero, cmpSign};
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Raise the selected key levels at a falling edge, hold them for a number
    // of cycles, release, and let one more edge pass before sampling.
    task automatic applyStimulus(input logic doNum, input logic [3:0] n,
                                 input logic doOpt, input logic [2:0] o,
                                 input logic doSub, input int hold);
        @(negedge clk);
        num        = n;
        opt        = o;
        numPressed = doNum;
        optPressed = doOpt;
        submit     = doSub;
        repeat (hold) @(negedge clk);
        numPressed = 1'b0;
        optPressed = 1'b0;
        submit     = 1'b0;
        @(negedge clk);
    endtask

    task automatic keyNum(input logic [3:0] n);
        applyStimulus(1'b1, n, 1'b0, 3'd0, 1'b0, 1);
    endtask

    task automatic keyOpt(input logic [2:0] o);
        applyStimulus(1'b0, 4'd0, 1'b1, o, 1'b0, 1);
    endtask

    task automatic keySubmit();
        applyStimulus(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1);
    endtask

    initial begin
        reset      = 1'b1;
        num        = 4'd0;
        numPressed = 1'b0;
        opt        = 3'd0;
        optPressed = 1'b0;
        submit     = 1'b0;
        #1;
        checkOutput("reset_state", 20'h00000);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        keyNum(4'd9);
        checkOutput("first_digit", 20'h00090);

        // Reset lands while a digit key is held down.
        @(negedge clk);
        num        = 4'd4;
        numPressed = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        #1 checkOutput("reset_async", 20'h00000);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("held_through_reset", 20'h00000);
        numPressed = 1'b0;
        @(negedge clk);

        keyOpt(3'd1);
        keyNum(4'd3);
        keySubmit();
        checkOutput("add_0_plus_3", 20'h00030);

        keyOpt(3'd2);
        checkOutput("opt_sub_clears", 20'h00000);
        keyNum(4'd1);
        checkOutput("digit_1", 20'h00010);
        keyNum(4'd2);
        checkOutput("digit_12", 20'h00120);
        keyNum(4'd3);
        checkOutput("digit_123", 20'h01230);
        keyNum(4'd4);
        checkOutput("digit_1234", 20'h12340);
        keySubmit();
        checkOutput("sub_3_minus_1234", 20'h12318);

        applyStimulus(1'b1, 4'd7, 1'b0, 3'd0, 1'b0, 5);
        checkOutput("long_press", 20'h00070);

        keyOpt(3'd4);
        keyNum(4'd1);
        keyNum(4'd2);
        keyNum(4'd3);
        keyNum(4'd4);
        keyNum(4'd5);
        checkOutput("entry_limit", 20'h12340);
        keySubmit();
        checkOutput("load_1234", 20'h12340);

        keyOpt(3'd4);
        repeat (4) keyNum(4'd9);
        keySubmit();
        checkOutput("load_9999", 20'h99990);
        keyOpt(3'd1);
        keyNum(4'd2);
        checkOutput("entry_0002", 20'h00020);
        keySubmit();
        checkOutput("add_overflow", 20'h00014);

        keyOpt(3'd4);
        keyNum(4'd5);
        keySubmit();
        checkOutput("load_5_clears_co", 20'h00050);
        keyOpt(3'd2);
        keyNum(4'd5);
        keySubmit();
        checkOutput("sub_to_zero", 20'h00002);

        keyOpt(3'd4);
        keyNum(4'd1);
        keyNum(4'd0);
        keySubmit();
        checkOutput("load_10", 20'h00100);
        keyOpt(3'd2);
        keyNum(4'd2);
        keyNum(4'd0);
        keySubmit();
        checkOutput("sub_10_minus_20", 20'h00108);
        keyOpt(3'd3);
        keyNum(4'd3);
        keySubmit();
        checkOutput("cmp_neg10_vs_3", 20'h00109);

        keyOpt(3'd0);
        checkOutput("clear_all", 20'h00000);

        keyNum(4'd4);
        checkOutput("entry_after_clear", 20'h00040);
        applyStimulus(1'b1, 4'd6, 1'b0, 3'd0, 1'b1, 1);
        checkOutput("submit_beats_num", 20'h00040);
        keyNum(4'd8);
        checkOutput("digit_after_result", 20'h00080);
        keyOpt(3'd5);
        checkOutput("opt_noop", 20'h00080);
        keyNum(4'd1);
        checkOutput("digit_after_noop", 20'h00810);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cu.md
# cu

Control unit of the music calculator. Collects BCD digit keys and operator keys, holds a signed 4-digit accumulator, and executes the pending operation on submit. It drives four BCD display digits plus sign, carry, zero and compare flags to the display and sound blocks. Key inputs come from the upstream keypad scanner and are edge-detected inside this block.

## Interface
- No parameters.
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `num` input 4: BCD digit of the key being pressed. Values >9 are ignored.
- `numPressed` input 1: digit key level, may stay high for many cycles.
- `opt` input 3: operator code. 0 = clear, 1 = add, 2 = subtract, 3 = compare, 4 = load, 5–7 = no-op.
- `optPressed` input 1: operator key level.
- `submit` input 1: execute (=) key level.
- `num1`..`num4` output 4 each: display digits. `num1` is thousands, `num4` is units.
- `sign` output 1: displayed value is negative.
- `clcCo` output 1: last add/sub magnitude overflowed past 9999.
- `clcZero` output 1: last result magnitude is 0 (for compare: operands are equal).
- `cmpSign` output 1: last compare found acc < entry.

## Operation
- Registers:
  - `entry`: 4-digit BCD value with a digit count of 0..4.
  - `acc`: sign plus 4-digit BCD magnitude.
  - `pend_op`: pending operator, 3 bits.
  - `disp_sel`: selects whether the display shows the entry or the result.
- Each key input is registered. An event is the rising edge of its level (previous sample 0, current 1). One press produces exactly one event.
- Event priority when events coincide: submit > opt > num. The lower-priority events in that cycle are dropped.
- Digit event (num ≤ 9):
  - If count < 4: shift the entry left one digit, insert num as the units digit, increment count, and show the entry.
  - If count = 4: ignore the event.
  - If the display was showing a result, the entry is cleared before the digit is inserted.
- Opt event:
  - Code 0: clear everything to reset values.
  - Codes 1–4: set `pend_op`, clear the entry and count to 0, and show the entry (0000).
  - Codes 5–7: no effect.
- Submit event: let E be the entry (always ≥0) and (s, A) the accumulator sign and magnitude.
  - ADD: if s=0, result is +(A+E). If s=1, result is E−A.
  - SUB: if s=0, result is A−E. If s=1, result is −(A+E).
  - Magnitude subtract X−Y gives +(X−Y) when X≥Y, otherwise −(Y−X).
  - Magnitude add: `clcCo`=1 if the sum exceeds 9999, and the kept magnitude is the sum mod 10000. Subtraction clears `clcCo`.
  - `clcZero` = (result magnitude == 0). When it is set, `sign` is forced to 0.
  - The result is written to `acc` and shown. `cmpSign` is unchanged.
  - LOAD: acc = +E. `clcCo` is cleared; `clcZero` follows the result.
  - COMPARE: acc is unchanged. `cmpSign` = (signed acc < E) and `clcZero` = (acc == E). The display shows acc; `clcCo` is unchanged.
  - The entry count is cleared. `pend_op` is retained for chained submits.
- `pend_op` resets to ADD, so digits followed by submit act as 0+E.

## Timing
- An event is detected at the clock edge that samples the level high after a low sample.
- All resulting register and output updates occur at that same edge. Latency from event to output is 1 cycle, with no busy period.
- The arithmetic datapath is combinational from `acc`, `entry` and `pend_op`. Every output is a register.
- Reset values, applied immediately and asynchronously:
  - `num1`..`num4` = 0, `sign` = 0, `clcCo` = 0, `clcZero` = 0, `cmpSign` = 0.
  - `acc` = +0000, entry = 0 with count 0, `pend_op` = ADD, display shows the entry.
  - Edge-detect registers = 0.
- Reset asserted during a press: after release, a key still held must return low before it can produce an event.

## Structure
- Shared package `cu_pkg`:
  - opcode constants `OP_CLR`=0, `OP_ADD`=1, `OP_SUB`=2, `OP_CMP`=3, `OP_LOAD`=4;
  - a BCD digit typedef (4 bits);
  - a signed-magnitude value type (sign plus four digits).
- Sub-module `bcd4_addsub`: 4-digit BCD magnitude adder/subtractor.
  - Inputs: X, Y, mode.
  - Outputs: magnitude, carry, and borrow (borrow means X<Y, with the magnitude already corrected to |X−Y|).
- The `cu` top holds edge detection, key handling, the sign logic and the output registers.

## Test plan
- Reset behaviour: assert reset mid-operation → every output reads 0 immediately. Then key opt 1, num 3, submit → display 0003, `sign`=0, `clcCo`=0, `clcZero`=0.
- Signed subtract: continuing, key opt 2, digits 1,2,3,4 → display shows 0001, 0012, 0123, 1234 in turn. Submit → display 1231 with `sign`=1.
- Long press and entry limit: hold `numPressed` for 5 cycles with num=7 → entry 0007 (one event only). Key a fifth digit after 1,2,3,4 → display stays 1234.
- Overflow: load 9999 (opt 4, digits 9999, submit), then add 0002 → display 0001, `clcCo`=1, `clcZero`=0.
- Zero result: load 0005, then subtract 0005 → display 0000, `clcZero`=1, `sign`=0.
- Compare and clear:
  - acc = −0010, compare with 0003 → `cmpSign`=1, `clcZero`=0, display 0010 with `sign`=1.
  - Press opt 0 → all outputs 0.
  - Simultaneous submit and num rising in one cycle → submit executes and the digit is dropped.
